// File: rtl/dmem_pkg.sv
// Shared constants, state encoding and address-check helper for the data-memory controller.
package dmem_pkg;

  localparam int DATA_W  = 32;
  localparam int BE_W    = DATA_W / 8;
  localparam int LAT_MAX = 8;
  localparam int CNT_W   = $clog2(LAT_MAX);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // Misaligned or beyond the last word: the request is answered but never touches the array.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a requester and dmem_ctrl.
interface dmem_if;
  import dmem_pkg::*;

  logic              req;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, be, addr, wdata, input ready, rvalid, rdata, err);
  modport slave  (input req, we, be, addr, wdata, output ready, rvalid, rdata, err);

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 storage with per-byte write enables and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic                     rd_clr,
  input  logic [BE_W-1:0]          wr_be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (wr_be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // The read register doubles as the held response data, so it clears on errors and reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_clr) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding data-memory controller with fixed request-to-response latency.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  dmem_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              we_reg;
  logic [BE_W-1:0]   be_reg;
  logic [31:0]       addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              err_reg;

  logic              accept;
  logic              enter_resp;
  logic              acc_we;
  logic [BE_W-1:0]   acc_be;
  logic [31:0]       acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_err;
  logic              acc_ok;
  logic              rd_en;
  logic [BE_W-1:0]   wr_be;

  assign accept     = (state_reg == ST_IDLE) && bus.req;
  assign enter_resp = (accept && (LATENCY == 1)) ||
                      ((state_reg == ST_WAIT) && (cnt_reg == '0));

  // With a one-cycle latency the access happens on the accepting edge, before the
  // request registers are loaded, so the live bus fields feed the array instead.
  assign acc_we    = (state_reg == ST_IDLE) ? bus.we    : we_reg;
  assign acc_be    = (state_reg == ST_IDLE) ? bus.be    : be_reg;
  assign acc_addr  = (state_reg == ST_IDLE) ? bus.addr  : addr_reg;
  assign acc_wdata = (state_reg == ST_IDLE) ? bus.wdata : wdata_reg;
  assign acc_err   = addr_bad(acc_addr, DEPTH);

  // rst_n gating keeps a request presented during reset from writing the array.
  assign acc_ok = enter_resp && !acc_err && rst_n;
  assign rd_en  = acc_ok && !acc_we;
  assign wr_be  = (acc_ok && acc_we) ? acc_be : '0;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.req) begin
          state_next = (LATENCY > 1) ? ST_WAIT : ST_RESP;
          cnt_next   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_reg == '0) begin
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      we_reg    <= 1'b0;
      be_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (enter_resp) begin
        err_reg <= acc_err;
      end
      if (accept) begin
        we_reg    <= bus.we;
        be_reg    <= bus.be;
        addr_reg  <= bus.addr;
        wdata_reg <= bus.wdata;
      end
    end
  end

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .rd_en (rd_en),
    .rd_clr(enter_resp && acc_err),
    .wr_be (wr_be),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (bus.rdata)
  );

  assign bus.ready  = (state_reg == ST_IDLE);
  assign bus.rvalid = (state_reg == ST_RESP);
  assign bus.err    = err_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (LATENCY 2, 1, 8) checked every cycle against a memory model.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int NK    = 3;
  localparam int DEPTH = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_s   [NK];
  logic        we_s    [NK];
  logic [3:0]  be_s    [NK];
  logic [31:0] addr_s  [NK];
  logic [31:0] wdata_s [NK];
  logic        ready_s [NK];
  logic        rvalid_s[NK];
  logic [31:0] rdata_s [NK];
  logic        err_s   [NK];

  int total = 0;
  int bad   = 0;

  dmem_if bus0();
  dmem_if bus1();
  dmem_if bus2();

  dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.req = req_s[0];  assign bus0.we = we_s[0];  assign bus0.be = be_s[0];
  assign bus0.addr = addr_s[0];  assign bus0.wdata = wdata_s[0];
  assign ready_s[0] = bus0.ready;  assign rvalid_s[0] = bus0.rvalid;
  assign rdata_s[0] = bus0.rdata;  assign err_s[0] = bus0.err;

  assign bus1.req = req_s[1];  assign bus1.we = we_s[1];  assign bus1.be = be_s[1];
  assign bus1.addr = addr_s[1];  assign bus1.wdata = wdata_s[1];
  assign ready_s[1] = bus1.ready;  assign rvalid_s[1] = bus1.rvalid;
  assign rdata_s[1] = bus1.rdata;  assign err_s[1] = bus1.err;

  assign bus2.req = req_s[2];  assign bus2.we = we_s[2];  assign bus2.be = be_s[2];
  assign bus2.addr = addr_s[2];  assign bus2.wdata = wdata_s[2];
  assign ready_s[2] = bus2.ready;  assign rvalid_s[2] = bus2.rvalid;
  assign rdata_s[2] = bus2.rdata;  assign err_s[2] = bus2.err;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 8;
  endfunction

  function automatic logic [31:0] pat(input int w);
    return {8'hC0, 8'(w), 8'h5A, 8'(w ^ 255)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: one pending request per instance, answered LATENCY cycles after acceptance.
  logic        pend   [NK];
  int          resp_c [NK];
  logic        p_we   [NK];
  logic [3:0]  p_be   [NK];
  logic [31:0] p_addr [NK];
  logic [31:0] p_wdata[NK];
  logic [31:0] rdm    [NK];
  logic [31:0] mem_m  [NK][DEPTH];
  int          rvcnt  [NK];
  int          rdylow [NK];
  int          cyc = 0;

  initial begin
    logic exp_rv, exp_rdy, e;
    int   w;
    for (int k = 0; k < NK; k++) begin
      pend[k] = 1'b0; rdm[k] = '0; rvcnt[k] = 0; rdylow[k] = 0; resp_c[k] = 0;
      for (int i = 0; i < DEPTH; i++) mem_m[k][i] = '0;
    end
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      for (int k = 0; k < NK; k++) begin
        if (!rst_n) begin
          pend[k] = 1'b0;
          rdm[k]  = '0;
        end
        exp_rdy = !pend[k];
        exp_rv  = pend[k] && (cyc == resp_c[k]);
        e       = 1'b0;
        if (exp_rv) begin
          e = (p_addr[k][1:0] != 2'b00) || (p_addr[k][31:2] >= 30'(DEPTH));
          if (e) begin
            rdm[k] = '0;
          end else begin
            w = int'(p_addr[k][31:2]);
            if (p_we[k]) begin
              for (int b = 0; b < 4; b++)
                if (p_be[k][b]) mem_m[k][w][8*b +: 8] = p_wdata[k][8*b +: 8];
            end else begin
              rdm[k] = mem_m[k][w];
            end
          end
        end
        chk($sformatf("k%0d ready c%0d", k, cyc), 32'(ready_s[k]), 32'(exp_rdy));
        chk($sformatf("k%0d rvalid c%0d", k, cyc), 32'(rvalid_s[k]), 32'(exp_rv));
        chk($sformatf("k%0d rdata c%0d", k, cyc), rdata_s[k], rdm[k]);
        if (exp_rv) chk($sformatf("k%0d err c%0d", k, cyc), 32'(err_s[k]), 32'(e));
        if (rvalid_s[k] === 1'b1) rvcnt[k]++;
        if (ready_s[k] !== 1'b1) rdylow[k]++;
        if (exp_rv) pend[k] = 1'b0;
        if (rst_n && exp_rdy && req_s[k]) begin
          pend[k]    = 1'b1;
          resp_c[k]  = cyc + lat_of(k);
          p_we[k]    = we_s[k];
          p_be[k]    = be_s[k];
          p_addr[k]  = addr_s[k];
          p_wdata[k] = wdata_s[k];
        end
      end
    end
  end

  // Issue one request, wait for its response; lat counts cycles from acceptance to rvalid.
  task automatic txn(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, output int lat, output logic [31:0] rd, output logic e);
    int n;
    @(negedge clk);
    we_s[k] = w; be_s[k] = b; addr_s[k] = a; wdata_s[k] = d; req_s[k] = 1'b1;
    n = 0;
    while (ready_s[k] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk($sformatf("k%0d accept timeout", k), 32'(n), 32'd0);
    @(negedge clk);
    req_s[k] = 1'b0;
    lat = 1;
    while (rvalid_s[k] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rdata_s[k];
    e  = err_s[k];
    $display("txn k%0d we=%0b be=%h addr=%h wdata=%h -> lat=%0d rdata=%h err=%0b",
             k, w, b, a, d, lat, rd, e);
  endtask

  task automatic b2b(input int k);
    int L;
    int n;
    L = lat_of(k);
    @(negedge clk);
    n = 0;
    while (ready_s[k] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    rvcnt[k] = 0; rdylow[k] = 0;
    we_s[k] = 1'b0; be_s[k] = 4'hF; addr_s[k] = 32'h10; req_s[k] = 1'b1;
    repeat (3 * (L + 1)) @(negedge clk);
    req_s[k] = 1'b0;
    repeat (L + 3) @(negedge clk);
    $display("b2b k%0d L=%0d rvalids=%0d ready_low=%0d", k, L, rvcnt[k], rdylow[k]);
    chk($sformatf("k%0d b2b rvalid count", k), 32'(rvcnt[k]), 32'd3);
    chk($sformatf("k%0d b2b ready low", k), 32'(rdylow[k]), 32'(3 * L));
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        e;
    int          n;
    for (int k = 0; k < NK; k++) begin
      req_s[k] = 1'b0; we_s[k] = 1'b0; be_s[k] = '0; addr_s[k] = '0; wdata_s[k] = '0;
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("reset ready", 32'(ready_s[0]), 32'd1);
    chk("reset rvalid", 32'(rvalid_s[0]), 32'd0);
    chk("reset rdata", rdata_s[2], 32'h0);

    for (int k = 0; k < NK; k++)
      for (int w = 0; w < DEPTH; w++) txn(k, 1'b1, 4'hF, 32'(w * 4), pat(w), lat, rd, e);

    txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, e);
    chk("wr lat", 32'(lat), 32'd2);
    chk("wr err", 32'(e), 32'd0);
    txn(0, 1'b0, 4'hF, 32'h10, 32'h0, lat, rd, e);
    chk("rd lat", 32'(lat), 32'd2);
    chk("rd data", rd, 32'hDEADBEEF);
    chk("rd err", 32'(e), 32'd0);

    txn(0, 1'b1, 4'hF, 32'h20, 32'h11223344, lat, rd, e);
    txn(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, lat, rd, e);
    txn(0, 1'b0, 4'hF, 32'h20, 32'h0, lat, rd, e);
    chk("merge", rd, 32'h11BB33DD);

    txn(0, 1'b1, 4'b0000, 32'h10, 32'h12345678, lat, rd, e);
    chk("be0 err", 32'(e), 32'd0);
    txn(0, 1'b0, 4'hF, 32'h10, 32'h0, lat, rd, e);
    chk("be0 unchanged", rd, 32'hDEADBEEF);

    txn(0, 1'b0, 4'hF, 32'h13, 32'h0, lat, rd, e);
    chk("misaligned err", 32'(e), 32'd1);
    chk("misaligned rdata", rd, 32'h0);
    txn(0, 1'b0, 4'hF, 32'hFC, 32'h0, lat, rd, e);
    chk("last word err", 32'(e), 32'd0);
    chk("last word data", rd, pat(63));
    txn(0, 1'b0, 4'hF, 32'h100, 32'h0, lat, rd, e);
    chk("oor rd err", 32'(e), 32'd1);
    chk("oor rd rdata", rd, 32'h0);
    txn(0, 1'b1, 4'hF, 32'h100, 32'hFFFFFFFF, lat, rd, e);
    chk("oor wr err", 32'(e), 32'd1);
    chk("oor wr lat", 32'(lat), 32'd2);
    for (int w = 0; w < DEPTH; w++) txn(0, 1'b0, 4'hF, 32'(w * 4), 32'h0, lat, rd, e);
    txn(0, 1'b0, 4'hF, 32'h0, 32'h0, lat, rd, e);
    chk("word0 intact", rd, pat(0));

    txn(1, 1'b1, 4'b1010, 32'h8, 32'h99887766, lat, rd, e);
    chk("L1 wr lat", 32'(lat), 32'd1);
    txn(1, 1'b0, 4'hF, 32'h8, 32'h0, lat, rd, e);
    chk("L1 rd data", rd, {8'h99, 8'h02, 8'h77, 8'hFD});

    b2b(1);
    b2b(2);
    b2b(0);

    // Reset in the middle of a long write's wait phase.
    txn(2, 1'b1, 4'hF, 32'h30, 32'h0, lat, rd, e);
    chk("L8 wr lat", 32'(lat), 32'd8);
    @(negedge clk);
    we_s[2] = 1'b1; be_s[2] = 4'hF; addr_s[2] = 32'h30; wdata_s[2] = 32'h55AA55AA; req_s[2] = 1'b1;
    n = 0;
    while (ready_s[2] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_s[2] = 1'b0;
    repeat (2) @(negedge clk);
    #7 rst_n = 1'b0;
    #1;
    chk("mid-wait rst ready", 32'(ready_s[2]), 32'd1);
    chk("mid-wait rst rvalid", 32'(rvalid_s[2]), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("post-rst ready", 32'(ready_s[2]), 32'd1);
    txn(2, 1'b0, 4'hF, 32'h30, 32'h0, lat, rd, e);
    chk("abandoned write", rd, 32'h0);
    chk("abandoned write err", 32'(e), 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit words, power of 2, range 16..4096.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response, range 1..8.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  1  request valid.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; qualified by req.
REQ-007 SHALL have port be  input  4  byte enables for writes, be[i] selects wdata[8i+7:8i].
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  write data.
REQ-010 SHALL have port ready  output  1  request accepted when req && ready at a rising edge.
REQ-011 SHALL have port rvalid  output  1  one-cycle response strobe for reads and writes.
REQ-012 SHALL have port rdata  output  32  read data, valid when rvalid && !we of the completed request.
REQ-013 SHALL have port err  output  1  error flag, valid when rvalid.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; one request outstanding at most.
REQ-015 SHALL drive ready = 1 only in IDLE.
REQ-016 SHALL on acceptance capture we, be, addr, wdata into request registers and go to WAIT if LATENCY > 1, else RESP.
REQ-017 SHALL stay in WAIT for exactly LATENCY-1 cycles using a down-counter of width clog2(8), then go to RESP.
REQ-018 SHALL perform the array access on the edge entering RESP: read samples word into rdata; write updates only lanes with be[i] = 1.
REQ-019 SHALL assert rvalid for exactly the single RESP cycle, then return to IDLE; accepted at edge ending cycle N, rvalid high in cycle N+LATENCY.
REQ-020 SHALL ignore req outside IDLE; requester holds req and fields until ready.
REQ-021 SHALL flag error when addr[1:0] != 0 or addr[31:2] >= DEPTH: no array access, err = 1, rdata = 0, timing unchanged.
REQ-022 SHALL treat a write with be = 4'b0000 as a legal no-op: normal ack, err = 0, array unchanged.
REQ-023 SHALL hold rdata between responses; write responses leave rdata unchanged.
REQ-024 SHALL give a read following a completed write to the same word the merged written value (no stale data).
REQ-025 SHALL index the array with addr[clog2(DEPTH)+1:2].

Reset
REQ-026 SHALL on rst_n low, immediately and asynchronously, force state IDLE, counter 0, rvalid 0, err 0, rdata 0; ready = 1 after release.
REQ-027 SHALL abandon any in-flight request on reset; a pending write SHALL NOT modify the array.
REQ-028 SHALL NOT reset array contents.

Structure
REQ-029 SHALL place the FSM state enum, LAT_MAX = 8 and the data-width constant 32 in shared package dmem_pkg.
REQ-030 SHALL instantiate one sub-module dmem_array: DEPTH x 32 storage, synchronous read, per-byte write enable.

Verification
REQ-031 LATENCY=2: write addr 0x10, be=4'hF, wdata 0xDEADBEEF, then read 0x10 -> write rvalid 2 cycles after accept, read rdata 0xDEADBEEF, err 0.
REQ-032 Byte merge: word 0x20 = 0x11223344, write be=4'b0101 wdata 0xAABBCCDD -> read returns 0x11BB33DD.
REQ-033 Errors: read addr 0x13 and, DEPTH=64, read addr 0x100 -> rvalid with err 1, rdata 0; write 0x100 leaves all words unchanged.
REQ-034 LATENCY=1 and LATENCY=8, back-to-back req held high -> ready low LATENCY cycles per request, one rvalid per request, throughput one per LATENCY+1 cycles.
REQ-035 Reset mid-WAIT of write 0x55AA55AA to 0x30 (old 0x0) -> rvalid 0 immediately, ready 1 after release, subsequent read 0x30 returns 0x0.
